fifo_ptr_ctrl: RTL and testbench

Pointer and flag controller for the 32-entry synchronous FIFO. It arbitrates push/pop requests against occupancy and issues write/read strobes to the storage array. It advances the write and read address counters (5-bit, wrap at 31→0) and produces registered full/empty/almost flags, an occupancy count and sticky error flags. It sits between the FIFO client ports and the storage RAM and sequences both address counters.

---
 rtl/fifo_ptr_ctrl_if.sv | 32 +++
 rtl/fifo_ptr_ctrl.sv | 80 ++++++++
 tb/tb_fifo_ptr_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ptr_ctrl_if.sv
// Client/RAM-side signal bundle for the 32-entry FIFO pointer controller.
// master drives requests and observes strobes/status; slave is the controller.
interface fifo_ptr_ctrl_if #(
   parameter int ADDR_W = 5
);
   logic              push;
   logic              pop;
   logic              err_clr;
   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              empty;
   logic              afull;
   logic              aempty;
   logic              ovf;
   logic              unf;

   modport master (
      output push, pop, err_clr,
      input  wr_en, rd_en, wr_addr, rd_addr, count,
      input  full, empty, afull, aempty, ovf, unf
   );

   modport slave (
      input  push, pop, err_clr,
      output wr_en, rd_en, wr_addr, rd_addr, count,
      output full, empty, afull, aempty, ovf, unf
   );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/flag controller: gates push/pop against occupancy, advances the
// wrapping RAM address counters and registers occupancy, status and sticky error flags.
module fifo_ptr_ctrl #(
   parameter int ADDR_W    = 5,
   parameter int AFULL_TH  = 28,
   parameter int AEMPTY_TH = 4
) (
   input logic            clk,
   input logic            clr,
   fifo_ptr_ctrl_if.slave bus
);
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH      = CNT_W'(1 << ADDR_W);
   localparam logic [CNT_W-1:0] AFULL_LVL  = CNT_W'(AFULL_TH);
   localparam logic [CNT_W-1:0] AEMPTY_LVL = CNT_W'(AEMPTY_TH);

   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              afull_q, afull_d;
   logic              aempty_q, aempty_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   always_comb begin
      // A pop frees a slot in the same cycle, so push+pop passes through when full.
      wr_en     = bus.push & (~full_q | bus.pop);
      rd_en     = bus.pop & ~empty_q;
      wr_addr_d = wr_addr_q + ADDR_W'(wr_en);
      rd_addr_d = rd_addr_q + ADDR_W'(rd_en);
      count_d   = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      full_d    = (count_d == DEPTH);
      empty_d   = (count_d == '0);
      afull_d   = (count_d >= AFULL_LVL);
      aempty_d  = (count_d <= AEMPTY_LVL);
      // A new error in the clearing cycle stays visible.
      ovf_d     = (bus.push & ~wr_en) | (ovf_q & ~bus.err_clr);
      unf_d     = (bus.pop & ~rd_en) | (unf_q & ~bus.err_clr);
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         afull_q   <= 1'b0;
         aempty_q  <= 1'b1;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         afull_q   <= afull_d;
         aempty_q  <= aempty_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign bus.wr_en   = wr_en;
   assign bus.rd_en   = rd_en;
   assign bus.wr_addr = wr_addr_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.count   = count_q;
   assign bus.full    = full_q;
   assign bus.empty   = empty_q;
   assign bus.afull   = afull_q;
   assign bus.aempty  = aempty_q;
   assign bus.ovf     = ovf_q;
   assign bus.unf     = unf_q;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed and randomized bench for fifo_ptr_ctrl with hand-derived expectations.
module tb_fifo_ptr_ctrl;
   logic clk = 1'b0;
   logic clr = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   fifo_ptr_ctrl_if #(.ADDR_W(5)) bus ();

   fifo_ptr_ctrl #(.ADDR_W(5), .AFULL_TH(28), .AEMPTY_TH(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   // status word: wr_addr, rd_addr, count, full, empty, afull, aempty, ovf, unf
   function automatic logic [21:0] status();
      return {bus.wr_addr, bus.rd_addr, bus.count, bus.full, bus.empty,
              bus.afull, bus.aempty, bus.ovf, bus.unf};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
      tick(); tick();
      clr = 1'b1;
      tick();
      n_vec++;
      if (status() !== {5'd0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL reset_idle got %h exp %h", status(), 22'h000014);
      end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 32; i++) begin
         bus.push = 1'b1;
         #1;
         n_vec++;
         if (bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL fill_wr_en push=%0d got %b exp 1", i, bus.wr_en); end
         tick();
         n_vec++;
         if (bus.count !== 6'(i) || bus.wr_addr !== 5'(i % 32) || bus.full !== (i == 32) ||
             bus.afull !== (i >= 28) || bus.aempty !== (i <= 4) || bus.empty !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_state push=%0d got count=%0d wa=%0d full=%b afull=%b aempty=%b empty=%b exp count=%0d wa=%0d full=%b afull=%b aempty=%b empty=0",
                     i, bus.count, bus.wr_addr, bus.full, bus.afull, bus.aempty, bus.empty,
                     i, i % 32, i == 32, i >= 28, i <= 4);
         end
      end
      #1;
      n_vec++;
      if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL push33_wr_en got %b exp 0", bus.wr_en); end
      tick();
      n_vec++;
      if (bus.ovf !== 1'b1 || bus.count !== 6'd32 || bus.wr_addr !== 5'd0) begin
         n_bad++; $display("FAIL push33_ovf got ovf=%b count=%0d wa=%0d exp ovf=1 count=32 wa=0", bus.ovf, bus.count, bus.wr_addr);
      end
      bus.err_clr = 1'b1;
      tick();
      n_vec++;
      if (bus.ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins got %b exp 1", bus.ovf); end
      bus.push = 1'b0;
      tick();
      n_vec++;
      if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_err_clr got %b exp 0", bus.ovf); end
      bus.err_clr = 1'b0;
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 32; i++) begin
         bus.pop = 1'b1;
         #1;
         n_vec++;
         if (bus.rd_en !== 1'b1) begin n_bad++; $display("FAIL drain_rd_en pop=%0d got %b exp 1", i, bus.rd_en); end
         tick();
         n_vec++;
         if (bus.count !== 6'(32 - i) || bus.rd_addr !== 5'(i % 32) || bus.empty !== (i == 32) ||
             bus.aempty !== (32 - i <= 4) || bus.full !== 1'b0 || bus.afull !== (32 - i >= 28)) begin
            n_bad++;
            $display("FAIL drain_state pop=%0d got count=%0d ra=%0d empty=%b aempty=%b full=%b afull=%b exp count=%0d ra=%0d empty=%b aempty=%b full=0 afull=%b",
                     i, bus.count, bus.rd_addr, bus.empty, bus.aempty, bus.full, bus.afull,
                     32 - i, i % 32, i == 32, 32 - i <= 4, 32 - i >= 28);
         end
      end
      #1;
      n_vec++;
      if (bus.rd_en !== 1'b0) begin n_bad++; $display("FAIL pop33_rd_en got %b exp 0", bus.rd_en); end
      tick();
      n_vec++;
      if (bus.unf !== 1'b1 || bus.count !== 6'd0 || bus.rd_addr !== 5'd0) begin
         n_bad++; $display("FAIL pop33_unf got unf=%b count=%0d ra=%0d exp unf=1 count=0 ra=0", bus.unf, bus.count, bus.rd_addr);
      end
      bus.pop = 1'b0; bus.err_clr = 1'b1;
      tick();
      n_vec++;
      if (bus.unf !== 1'b0) begin n_bad++; $display("FAIL unf_err_clr got %b exp 0", bus.unf); end
      bus.err_clr = 1'b0;
   endtask

   task automatic test_boundaries();
      bus.push = 1'b1; bus.pop = 1'b1;
      #1;
      n_vec++;
      if ({bus.wr_en, bus.rd_en} !== 2'b10) begin n_bad++; $display("FAIL empty_pushpop_strobes got %b exp 10", {bus.wr_en, bus.rd_en}); end
      tick();
      n_vec++;
      if (status() !== {5'd1, 5'd0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL empty_pushpop_state got %h exp %h", status(), {5'd1, 5'd0, 6'd1, 6'b000101});
      end
      bus.pop = 1'b0; bus.err_clr = 1'b1;
      for (int i = 0; i < 31; i++) begin
         tick();
         bus.err_clr = 1'b0;
      end
      n_vec++;
      if (status() !== {5'd0, 5'd0, 6'd32, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL refill_state got %h exp %h", status(), {5'd0, 5'd0, 6'd32, 6'b101000});
      end
      bus.pop = 1'b1;
      #1;
      n_vec++;
      if ({bus.wr_en, bus.rd_en} !== 2'b11) begin n_bad++; $display("FAIL full_pushpop_strobes got %b exp 11", {bus.wr_en, bus.rd_en}); end
      tick();
      n_vec++;
      if (status() !== {5'd1, 5'd1, 6'd32, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL full_pushpop_state got %h exp %h", status(), {5'd1, 5'd1, 6'd32, 6'b101000});
      end
      bus.push = 1'b0; bus.pop = 1'b0;
   endtask

   task automatic test_mid_reset();
      bus.pop = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      bus.pop = 1'b0;
      n_vec++;
      if (bus.count !== 6'd17 || bus.rd_addr !== 5'd16) begin
         n_bad++; $display("FAIL pre_reset_count got count=%0d ra=%0d exp count=17 ra=16", bus.count, bus.rd_addr);
      end
      clr = 1'b0; bus.push = 1'b1;
      tick();
      clr = 1'b1; bus.push = 1'b0;
      n_vec++;
      if (status() !== {5'd0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL mid_reset got %h exp %h", status(), 22'h000014);
      end
      tick();
      n_vec++;
      if (status() !== {5'd0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL post_reset_idle got %h exp %h", status(), 22'h000014);
      end
   endtask

   task automatic test_soak();
      int  m_cnt = 0, m_wa = 0, m_ra = 0;
      bit  m_ovf = 0, m_unf = 0;
      bit  e_we, e_re;
      int  bias;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         bias = ((cyc / 400) % 2 == 0) ? 70 : 30;
         bus.push    = ($urandom_range(0, 99) < bias);
         bus.pop     = ($urandom_range(0, 99) < 100 - bias);
         bus.err_clr = ($urandom_range(0, 15) == 0);
         #1;
         e_we = bus.push && (m_cnt < 32 || bus.pop);
         e_re = bus.pop && (m_cnt > 0);
         n_vec++;
         if (bus.wr_en !== e_we || bus.rd_en !== e_re) begin
            n_bad++; $display("FAIL soak_strobes cyc=%0d got we=%b re=%b exp we=%b re=%b", cyc, bus.wr_en, bus.rd_en, e_we, e_re);
         end
         m_ovf = (bus.push && !e_we) || (m_ovf && !bus.err_clr);
         m_unf = (bus.pop && !e_re) || (m_unf && !bus.err_clr);
         m_cnt = m_cnt + int'(e_we) - int'(e_re);
         m_wa  = (m_wa + int'(e_we)) % 32;
         m_ra  = (m_ra + int'(e_re)) % 32;
         tick();
         n_vec++;
         if (bus.count !== 6'(m_cnt) || bus.wr_addr !== 5'(m_wa) || bus.rd_addr !== 5'(m_ra) ||
             bus.full !== (m_cnt == 32) || bus.empty !== (m_cnt == 0) || bus.afull !== (m_cnt >= 28) ||
             bus.aempty !== (m_cnt <= 4) || bus.ovf !== m_ovf || bus.unf !== m_unf) begin
            n_bad++;
            $display("FAIL soak_state cyc=%0d got count=%0d wa=%0d ra=%0d flags(f,e,af,ae,o,u)=%b%b%b%b%b%b exp count=%0d wa=%0d ra=%0d",
                     cyc, bus.count, bus.wr_addr, bus.rd_addr, bus.full, bus.empty, bus.afull, bus.aempty,
                     bus.ovf, bus.unf, m_cnt, m_wa, m_ra);
         end
         n_vec++;
         if (5'(bus.wr_addr - bus.rd_addr) !== bus.count[4:0] || (bus.full && bus.empty)) begin
            n_bad++; $display("FAIL soak_invariant cyc=%0d got wa=%0d ra=%0d count=%0d full=%b empty=%b exp count%%32==wa-ra and not full&empty",
                              cyc, bus.wr_addr, bus.rd_addr, bus.count, bus.full, bus.empty);
         end
      end
      bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
   endtask

   initial begin
      bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
      test_reset();
      test_fill();
      test_drain();
      test_boundaries();
      test_mid_reset();
      test_soak();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
